vec_mac_pe: RTL and testbench

VEC_MAC_PE -- requirements
Module: vec_mac_pe

---
 rtl/vec_mac_pe.sv | 134 +++++++++++++
 tb/tb_vec_mac_pe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mac_pe.sv
// ============================================================================
// vec_mac_pe : LANES-wide signed multiply-accumulate PE with a 2-stage pipeline
// Optional clamp-on-overflow arithmetic with sticky sat_o: VEC_MAC_PE_SAT_EN
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vec_mac_pe #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int AW    = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*DW-1:0]   neuron,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [1:0]            ctl,
  input  logic                  vld_i,
  output logic                  rdy_o,
  output logic [AW-1:0]         result,
  output logic                  vld_o,
  input  logic                  rdy_i
`ifdef VEC_MAC_PE_SAT_EN
  ,output logic                 sat_o
`endif
);

  localparam int PW = 2 * DW;

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("vec_mac_pe: LANES must be in 1..16");
  end
  if (AW < 2 * DW + $clog2(LANES)) begin : g_bad_aw
    $error("vec_mac_pe: AW too narrow for LANES full-precision products");
  end

  logic                 r_s1_vld;
  logic [1:0]           r_s1_ctl;
  logic signed [PW-1:0] r_prod [LANES];
  logic signed [PW-1:0] w_prod [LANES];
  logic signed [AW-1:0] w_tree;
  logic signed [AW-1:0] w_acc_next;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] r_result;
  logic                 r_vld;
  logic                 w_load;

  // A held output blocks the whole pipeline; otherwise everything advances.
  assign rdy_o  = !r_vld | rdy_i;
  assign w_load = r_s1_vld & r_s1_ctl[1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_prod[i] = PW'($signed(neuron[i*DW +: DW])) * PW'($signed(weight[i*DW +: DW]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_ctl <= 2'b00;
      for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
    end else if (rdy_o) begin
      r_s1_vld <= vld_i;
      if (vld_i) begin
        r_s1_ctl <= ctl;
        for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
      end
    end
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < LANES; i++) w_tree = w_tree + AW'(r_prod[i]);
  end

`ifdef VEC_MAC_PE_SAT_EN
  localparam logic signed [AW-1:0] c_acc_max = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] c_acc_min = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW:0] w_sum_wide;
  logic               w_clamp;
  logic               w_flag_next;
  logic               r_sat_flag;
  logic               r_sat;

  // One guard bit exposes overflow of acc + tree before it wraps.
  assign w_sum_wide = (AW+1)'(r_acc) + (AW+1)'(w_tree);

  always_comb begin
    w_clamp    = 1'b0;
    w_acc_next = w_sum_wide[AW-1:0];
    if (r_s1_ctl[0]) begin
      w_acc_next = w_tree;
    end else if (w_sum_wide[AW] != w_sum_wide[AW-1]) begin
      w_clamp    = 1'b1;
      w_acc_next = w_sum_wide[AW] ? c_acc_min : c_acc_max;
    end
  end

  assign w_flag_next = (r_s1_ctl[0] ? 1'b0 : r_sat_flag) | w_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
      r_sat      <= 1'b0;
    end else if (rdy_o && r_s1_vld) begin
      r_sat_flag <= w_flag_next;
      if (r_s1_ctl[1]) r_sat <= w_flag_next;
    end
  end

  assign sat_o = r_sat;
`else
  assign w_acc_next = r_s1_ctl[0] ? w_tree : r_acc + w_tree;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_result <= '0;
      r_vld    <= 1'b0;
    end else if (rdy_o) begin
      if (r_s1_vld) r_acc <= w_acc_next;
      if (w_load) r_result <= w_acc_next;
      r_vld <= w_load;
    end
  end

  assign result = r_result;
  assign vld_o  = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_vec_mac_pe.sv
// ============================================================================
// tb_vec_mac_pe : directed-vector bench, AW=40 and AW=34 instances on one stimulus
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vec_mac_pe;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int AWA   = 40;
  localparam int AWB   = 34;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LANES*DW-1:0] neuron = '0;
  logic [LANES*DW-1:0] weight = '0;
  logic [1:0]          ctl = 2'b00;
  logic                vld_i = 1'b0;
  logic                rdy_i = 1'b1;
  logic                rdy_a, vld_a, rdy_b, vld_b;
  logic [AWA-1:0]      res_a;
  logic [AWB-1:0]      res_b;
`ifdef VEC_MAC_PE_SAT_EN
  logic                sat_a, sat_b;
`endif

  always #5 clk = ~clk;

  vec_mac_pe #(.LANES(LANES), .DW(DW), .AW(AWA)) dut (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .rdy_o(rdy_a), .result(res_a), .vld_o(vld_a), .rdy_i(rdy_i)
`ifdef VEC_MAC_PE_SAT_EN
    , .sat_o(sat_a)
`endif
  );

  vec_mac_pe #(.LANES(LANES), .DW(DW), .AW(AWB)) dut34 (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .rdy_o(rdy_b), .result(res_b), .vld_o(vld_b), .rdy_i(rdy_i)
`ifdef VEC_MAC_PE_SAT_EN
    , .sat_o(sat_b)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  // Running dot product by plain integer arithmetic, then wrapped or clamped to w bits.
  function automatic longint step(input longint acc, input longint s, input bit first,
                                  input int w, inout bit flag);
    longint t, mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    if (first) begin
      flag = 1'b0;
      t = s;
    end else begin
      t = acc + s;
    end
`ifdef VEC_MAC_PE_SAT_EN
    if (t > mx) begin t = mx; flag = 1'b1; end
    else if (t < mn) begin t = mn; flag = 1'b1; end
    return t;
`else
    if (mx < mn) flag = 1'b1;
    return wrap(t, w);
`endif
  endfunction

  typedef struct {
    longint ra;
    longint rb;
    bit     sa;
    bit     sb;
    int     due;
  } exp_t;

  exp_t   q[$];
  longint obs_a[$];
  longint obs_b[$];
  bit     obs_s[$];
  longint acc_a = 0, acc_b = 0;
  bit     flag_a = 1'b0, flag_b = 1'b0;

  always @(negedge clk) begin
    longint s;
    cyc++;
    if (!rst_n) begin
      q.delete();
      acc_a = 0; acc_b = 0; flag_a = 1'b0; flag_b = 1'b0;
      chk("rst_vld_o", vld_a, 0);
      chk("rst_rdy_o", rdy_a, 1);
      chk("rst_result", $signed(res_a), 0);
      chk("rst_result34", $signed(res_b), 0);
    end else begin
      chk("rdy_o", rdy_a, !vld_a | rdy_i);
      chk("rdy_o34", rdy_b, rdy_a);
      chk("vld_o34", vld_b, vld_a);
      if (vld_a) begin
        if (q.size() == 0) begin
          chk("spurious_vld_o", 1, 0);
        end else begin
          if (q[0].due != 0 && cyc < q[0].due) chk("early_vld_o", cyc, q[0].due);
          chk("result", $signed(res_a), q[0].ra);
          chk("result34", $signed(res_b), q[0].rb);
`ifdef VEC_MAC_PE_SAT_EN
          chk("sat_o", sat_a, q[0].sa);
          chk("sat_o34", sat_b, q[0].sb);
`endif
          if (rdy_i) begin
            obs_a.push_back($signed(res_a));
            obs_b.push_back($signed(res_b));
`ifdef VEC_MAC_PE_SAT_EN
            obs_s.push_back(sat_b);
`else
            obs_s.push_back(1'b0);
`endif
            void'(q.pop_front());
          end
        end
      end else if (q.size() > 0 && q[0].due != 0 && cyc >= q[0].due) begin
        chk("latency_vld_o", 0, 1);
        q[0].due = 0;
      end
      if (vld_i && rdy_a) begin
        s = 0;
        for (int k = 0; k < LANES; k++)
          s += longint'($signed(neuron[k*DW +: DW])) * longint'($signed(weight[k*DW +: DW]));
        acc_a = step(acc_a, s, ctl[0], AWA, flag_a);
        acc_b = step(acc_b, s, ctl[0], AWB, flag_b);
        if (ctl[1])
          q.push_back('{acc_a, acc_b, flag_a, flag_b, (q.size() == 0) ? cyc + 2 : 0});
      end
    end
  end

  function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic drive(input logic [1:0] c, input logic [63:0] n, input logic [63:0] w);
    ctl = c; neuron = n; weight = w; vld_i = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = rdy_a;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    vld_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] c, input logic [63:0] n, input logic [63:0] w);
    drive(c, n, w);
    wait_accept();
  endtask

  task automatic wait_results(input int k);
    for (int t = 0; t < 50 && obs_a.size() < k; t++) @(negedge clk);
    if (obs_a.size() < k) chk("result_timeout", obs_a.size(), k);
    @(posedge clk); #1;
  endtask

  longint       r0;
  logic [63:0]  n1, nm;

  initial begin
    n1 = p4(1, 1, 1, 1);
    nm = p4(-32768, -32768, -32768, -32768);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ctl=00 straight after reset accumulates onto zero.
    send(2'b00, n1, p4(1, 2, 3, 4));
    send(2'b10, n1, p4(2, 4, 6, 8));
    wait_results(1);
    chk("no_first_beat_30", obs_a[0], 30);

    send(2'b11, p4(2, 2, 2, 2), p4(3, 4, 5, 6));
    wait_results(2);
    chk("single_beat_36", obs_a[1], 36);

    send(2'b01, n1, p4(1, 2, 3, 4));
    send(2'b00, n1, p4(2, 4, 6, 8));
    send(2'b10, n1, p4(3, 6, 9, 12));
    send(2'b11, n1, p4(1, 1, 1, 2));
    wait_results(4);
    chk("three_beat_60", obs_a[2], 60);
    chk("followup_5", obs_a[3], 5);

    send(2'b11, p4(-1, -1, -1, -1), p4(32767, 32767, 32767, 32767));
    wait_results(5);
    chk("neg_one_sum", obs_a[4], -131068);
    chk("neg_one_sum34", obs_b[4], -131068);

    send(2'b11, nm, nm);
    wait_results(6);
    r0 = 64'sd4294967296;
    chk("most_neg_squared", obs_a[5], r0);

    send(2'b01, nm, nm);
    send(2'b10, nm, nm);
    wait_results(7);
    r0 = 64'sd8589934592;
    chk("two_max_beats_40", obs_a[6], r0);
`ifdef VEC_MAC_PE_SAT_EN
    r0 = 64'sd8589934591;
    chk("two_max_beats_34_sat", obs_b[6], r0);
    chk("sat_flag_set", obs_s[6], 1);
`else
    r0 = -64'sd8589934592;
    chk("two_max_beats_34_wrap", obs_b[6], r0);
`endif
    send(2'b11, p4(2, 2, 2, 2), p4(3, 4, 5, 6));
    wait_results(8);
    chk("after_sat_34", obs_b[7], 36);
    chk("sat_flag_cleared", obs_s[7], 0);

    // Downstream stall: A on the output, B parked in S1, C held at the input.
    rdy_i = 1'b0;
    send(2'b11, p4(2, 2, 2, 2), p4(3, 4, 5, 6));
    send(2'b11, n1, p4(2, 4, 6, 8));
    drive(2'b01, n1, p4(1, 2, 3, 4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rdy_o", rdy_a, 0);
      chk("bp_vld_o", vld_a, 1);
      chk("bp_result_held", $signed(res_a), 36);
    end
    @(posedge clk); #1;
    rdy_i = 1'b1;
    wait_accept();
    send(2'b10, n1, p4(2, 4, 6, 8));
    wait_results(11);
    chk("bp_first", obs_a[8], 36);
    chk("bp_second", obs_a[9], 20);
    chk("bp_queued", obs_a[10], 30);

    // Reset in the middle of a dot product.
    send(2'b01, n1, p4(1, 2, 3, 4));
    send(2'b00, n1, p4(2, 4, 6, 8));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld_o", vld_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'b01, n1, p4(1, 2, 3, 4));
    send(2'b00, n1, p4(2, 4, 6, 8));
    send(2'b00, n1, p4(3, 6, 9, 12));
    send(2'b10, n1, p4(1, 1, 1, 2));
    wait_results(12);
    chk("after_reset_65", obs_a[11], 65);

    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
